// File: rtl/addsub_div_ctrl.sv
// addsub: 4-bit adder/subtractor; m=1 computes a-b with c=1 meaning no borrow.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of inputs.
module addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] s,
  output logic       c,
  output logic       v
);

  logic [3:0] bx;
  logic [4:0] sum;

  assign bx  = b ^ {4{m}};
  assign sum = {1'b0, a} + {1'b0, bx} + {4'b0, m};
  assign s   = sum[3:0];
  assign c   = sum[4];
  assign v   = (a[3] == bx[3]) & (s[3] != a[3]);

endmodule

// addsub_div_ctrl: 4-bit unsigned restoring divider, one quotient bit per cycle via addsub.
// Latency: 5 edges start-to-done; divide-by-zero completes in 1 edge.
// Backpressure: start is only accepted in IDLE/DONE; start during RUN is dropped, not queued.
module addsub_div_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic       dbz,
  output logic [3:0] quotient,
  output logic [3:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] rem_r, rem_nxt;
  logic [3:0] quo_r, quo_nxt;
  logic [3:0] dvs_r, dvs_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [3:0] quotient_nxt, remainder_nxt;
  logic       dbz_nxt;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  logic [3:0] sub_a, sub_s, step_rem, step_quo;
  logic       sub_c, unused_v;

  assign sub_a = {rem_r[2:0], quo_r[3]};

  addsub u_addsub (
    .a (sub_a),
    .b (dvs_r),
    .m (1'b1),
    .s (sub_s),
    .c (sub_c),
    .v (unused_v)
  );

  assign step_rem = sub_c ? sub_s : sub_a;
  assign step_quo = {quo_r[2:0], sub_c};

  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem_r;
    quo_nxt       = quo_r;
    dvs_nxt       = dvs_r;
    cnt_nxt       = cnt;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    dbz_nxt       = dbz;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start) begin
          if (divisor != 4'd0) begin
            quo_nxt   = dividend;
            dvs_nxt   = divisor;
            rem_nxt   = 4'd0;
            cnt_nxt   = 2'd0;
            dbz_nxt   = 1'b0;
            state_nxt = S_RUN;
          end else begin
            quotient_nxt  = 4'hF;
            remainder_nxt = dividend;
            dbz_nxt       = 1'b1;
            state_nxt     = S_DONE;
          end
        end
      end
      S_RUN: begin
        rem_nxt = step_rem;
        quo_nxt = step_quo;
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          quotient_nxt  = step_quo;
          remainder_nxt = step_rem;
          state_nxt     = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy/done are registered decodes of the next state so outputs never see inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r     <= 4'd0;
      quo_r     <= 4'd0;
      dvs_r     <= 4'd0;
      cnt       <= 2'd0;
      quotient  <= 4'd0;
      remainder <= 4'd0;
      dbz       <= 1'b0;
    end else begin
      rem_r     <= rem_nxt;
      quo_r     <= quo_nxt;
      dvs_r     <= dvs_nxt;
      cnt       <= cnt_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
      dbz       <= dbz_nxt;
    end
  end

endmodule

// File: tb/tb_addsub_div_ctrl.sv
// Directed bench for addsub_div_ctrl: hand-computed quotient/remainder, latency and handshake checks.
module tb_addsub_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       busy, done, dbz;
  logic [3:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;

  addsub_div_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done and check the result.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                         input logic [3:0] er, input logic edbz, input int elat,
                         input string tag);
    int n;
    int nbusy;
    int nboth;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    n = 1; nbusy = 0; nboth = 0;
    while (!done && n < 12) begin
      nbusy += int'(busy);
      @(negedge clk);
      n++;
    end
    nboth = int'(busy & done);
    chk({tag, "_lat"}, 8'(n), 8'(elat));
    chk({tag, "_busycyc"}, 8'(nbusy), 8'(elat - 1));
    chk({tag, "_busydone"}, 8'(nboth), 8'd0);
    chk({tag, "_q"}, {4'd0, quotient}, {4'd0, eq});
    chk({tag, "_r"}, {4'd0, remainder}, {4'd0, er});
    chk({tag, "_dbz"}, {7'd0, dbz}, {7'd0, edbz});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {5'd0, busy, done, dbz}, 8'd0);
    chk("rst_res", {quotient, remainder}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 13/3 and hold after done falls.
    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, "d13_3");
    @(negedge clk);
    chk("d13_3_donefall", {7'd0, done}, 8'd0);
    repeat (2) @(negedge clk);
    chk("d13_3_hold", {quotient, remainder}, 8'h41);

    // Corner values.
    run_div(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5, "d15_1");
    run_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5, "d15_15");
    run_div(4'd0,  4'd7,  4'd0,  4'd0, 1'b0, 5, "d0_7");
    run_div(4'd6,  4'd9,  4'd0,  4'd6, 1'b0, 5, "d6_9");
    run_div(4'd15, 4'd2,  4'd7,  4'd1, 1'b0, 5, "d15_2");

    // Divide by zero, then a valid op clears dbz.
    run_div(4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1, "d9_0");
    run_div(4'd8, 4'd4, 4'd2, 4'd0, 1'b0, 5, "d8_4");

    // Back-to-back: start held high, new operands presented in the DONE cycle.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 12);
    chk("b2b1_lat", 8'(n), 8'd5);
    chk("b2b1_qr", {quotient, remainder}, 8'h42);
    dividend = 4'd11; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_nogap", {6'd0, busy, done}, 8'b10);
    n = 1;
    while (!done && n < 12) begin @(negedge clk); n++; end
    chk("b2b2_lat", 8'(n), 8'd5);
    chk("b2b2_qr", {quotient, remainder}, 8'h21);
    @(negedge clk);
    chk("b2b2_single", {7'd0, done}, 8'd0);

    // start re-pulsed during RUN is ignored: 12/5 -> q=2 r=2.
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 12) begin @(negedge clk); n++; end
    chk("ign_lat", 8'(n), 8'd5);
    chk("ign_qr", {quotient, remainder}, 8'h22);
    @(negedge clk);
    chk("ign_noqueue", {6'd0, busy, done}, 8'b00);

    // Reset during the 2nd RUN cycle abandons the operation.
    @(negedge clk);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ctl", {5'd0, busy, done, dbz}, 8'd0);
    chk("mrst_res", {quotient, remainder}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (7) begin @(negedge clk); n += int'(done | busy); end
    chk("mrst_nodone", 8'(n), 8'd0);
    run_div(4'd10, 4'd4, 4'd2, 4'd2, 1'b0, 5, "d10_4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_div_ctrl.md
# addsub_div_ctrl

Sequential controller that performs 4-bit unsigned restoring division by driving one internal instance of the team's 4-bit ADDSUB unit in subtract mode, one quotient bit per cycle. It sits beside the ALU datapath and gives the lab processor a multi-cycle DIV/REM capability. It uses a start/busy/done handshake and flags divide-by-zero.

## Interface
- Parameters: none; width is fixed at 4 bits to match ADDSUB.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  4  unsigned dividend; captured on accepted start.
- divisor  input  4  unsigned divisor; captured on accepted start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse when results become valid.
- dbz  output  1  divide-by-zero flag for the last operation.
- quotient  output  4  unsigned quotient, registered.
- remainder  output  4  unsigned remainder, registered.

## Operation
- Internal registers:
  - R[3:0]: partial remainder.
  - Q[3:0]: shifting dividend/quotient.
  - D[3:0]: captured divisor.
  - cnt[1:0]: iteration counter.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 with divisor!=0: load Q=dividend, D=divisor, R=0, cnt=0, clear dbz, go to RUN.
  - start=1 with divisor=0: set quotient=4'hF, remainder=dividend, dbz=1, go to DONE.
- RUN, each cycle:
  - ADDSUB is driven with A={R[2:0],Q[3]}, B=D, M=1.
  - If carry-out C=1 (no borrow, A>=D): R<=S and Q<={Q[2:0],1}.
  - If C=0: R<={R[2:0],Q[3]} and Q<={Q[2:0],0}.
  - V is ignored.
  - R[3] is always 0 on entry to every step because R < 2^k after k steps, so no fifth bit is required.
  - cnt increments every cycle. On the cycle with cnt=3, write the final Q/R values into quotient/remainder and go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- quotient, remainder and dbz hold their values until the next accepted start rewrites them.
- A valid start clears dbz. A divide-by-zero start sets it.
- start in RUN is ignored; it is not queued.
- dividend and divisor are don't-care except on the accepted-start edge.
- There are no illegal state encodings. Any unused encoding returns to IDLE.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, dbz=0.
  - quotient=0, remainder=0.
  - R, Q, D and cnt are all 0.
  - Takes effect immediately, including mid-RUN. The operation is abandoned and no done is produced.
- Normal latency, with start sampled at edge E0:
  - busy=1 from after E0 through E4.
  - Iterations occur at E1..E4.
  - Results and done=1 are visible after E4; done is low again after E5.
  - Start-to-done is 5 edges.
- Divide-by-zero latency: done=1, dbz=1 and the results are visible after E0. busy is never asserted.
- Back-to-back: start high during the DONE cycle is captured at that edge. busy rises after that edge with no IDLE cycle in between.
- busy and done are never high in the same cycle.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan
- Reset, then 13/3: start pulse gives busy for 4 cycles, then done pulse with quotient=4, remainder=1, dbz=0. Values hold after done falls.
- Corner values: 15/1 gives q=15 r=0; 15/15 gives q=1 r=0; 0/7 gives q=0 r=0; 6/9 gives q=0 r=6; 15/2 gives q=7 r=1. Each takes 5 edges start-to-done.
- Divide by zero, 9/0: done after 1 edge with dbz=1, q=4'hF, r=9, busy never high. A following 8/4 gives q=2 r=0 with dbz cleared.
- start held high continuously with a new operand each DONE (14/3, then 11/5): results are q=4 r=2 and then q=2 r=1. No IDLE gap; each done is a single cycle.
- start re-pulsed with different operands during RUN: it is ignored, and the original result is produced on schedule.
- rst_n pulled low during the 2nd RUN cycle: outputs zero immediately and no done follows. After release, a new 10/4 gives q=2 r=2.
